bank_scheduler_n: RTL and testbench
===================================

Name: bank_scheduler_n

Overview:
- N-port arbiter/scheduler in front of one single-port BRAM bank that owns the address window [LOWER_ADDR, UPPER_ADDR].
- Every cycle it grants at most one in-range requester, drives the bank with registered address/data/enable, and routes read data back to the granted port after a fixed memory latency.
- Parametrised successor of the 4-port diffusion_rw scheduler, adding:
  - generic port count;
  - fixed-priority or round-robin mode;
  - a valid/ready handshake;
  - tracking of in-flight reads.

Parameters:
- NUM_PORTS, 4, number of requesting M modules.
- ADDR_WIDTH, 13, global address width.
- DATA_WIDTH, 32, data word width.
- LOWER_ADDR, 0, first global address owned by this bank (inclusive).
- UPPER_ADDR, 4, last global address owned by this bank (inclusive).
- RR_MODE, 1, 0 = fixed priority (port 0 highest), 1 = round robin.
- MEM_LATENCY, 1, cycles from registered mem_en to valid mem_rdata (range 1..4).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_PORTS  per-port request valid.
- req_we  in  NUM_PORTS  per-port write enable (1 = write, 0 = read).
- req_addr  in  NUM_PORTS*ADDR_WIDTH  packed global addresses; port i occupies slice i.
- req_wdata  in  NUM_PORTS*DATA_WIDTH  packed write data.
- req_ready  out  NUM_PORTS  one-hot grant; combinational, same cycle as the request.
- conflict  out  NUM_PORTS  per-port stall flag; combinational.
- mem_en  out  1  registered bank enable.
- mem_we  out  1  registered bank write enable.
- mem_addr  out  ADDR_WIDTH  registered local address.
- mem_wdata  out  DATA_WIDTH  registered write data.
- mem_rdata  in  DATA_WIDTH  bank read data.
- rsp_valid  out  NUM_PORTS  one-hot read-response strobe.
- rsp_data  out  DATA_WIDTH  read data, broadcast to all ports; qualified by rsp_valid.

Behaviour:
- Range check: in_range[i] = (req_addr_i >= LOWER_ADDR) && (req_addr_i <= UPPER_ADDR). Both compares are unsigned and evaluated separately; no chained compares.
- Eligibility: eligible[i] = req_valid[i] & in_range[i]. Out-of-range requests are ignored: ready = 0 and conflict = 0 for that port.
- Grant:
  - Exactly one eligible port is granted per cycle; none if no port is eligible.
  - RR_MODE = 0: the lowest-index eligible port wins.
  - RR_MODE = 1: the first eligible port at or after rr_ptr wins, searching upward with wrap from NUM_PORTS-1 to 0.
  - rr_ptr updates to (granted index + 1) mod NUM_PORTS on the clock edge ending a grant cycle. It holds when there is no grant.
- Handshake:
  - A transfer occurs on any edge where req_valid[i] & req_ready[i].
  - A requester must hold valid/addr/we/wdata stable until it is granted.
  - conflict[i] = eligible[i] & ~req_ready[i].
- Issue: on the edge ending grant cycle t:
  - mem_en <= 1, mem_we <= req_we[g];
  - mem_addr <= (req_addr_g - LOWER_ADDR), truncated to ADDR_WIDTH;
  - mem_wdata <= req_wdata_g.
  - With no grant: mem_en <= 0 and mem_we <= 0; mem_addr and mem_wdata hold.
- Read return:
  - Reads are tracked by a shift pipe of depth MEM_LATENCY carrying {valid, port id}; writes push valid = 0.
  - rsp_valid[id] = 1 during cycle t+1+MEM_LATENCY; rsp_data = mem_rdata.
  - Back-to-back reads from any ports give one response per cycle, in issue order.
- Write return: writes produce no response.
- Throughput: one access per cycle. There are no bubbles between consecutive grants.
- Reset (async assert, sync release):
  - mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - rr_ptr = 0; response pipe cleared, so rsp_valid = 0.
  - req_ready and conflict follow the inputs combinationally, but grant is forced to 0 while rst_n = 0.
  - Reset mid-operation discards in-flight reads; no response is produced for them.
- Boundaries:
  - Addresses equal to LOWER_ADDR map to local 0.
  - Addresses equal to UPPER_ADDR are in range.
  - UPPER_ADDR + 1 is out of range.
  - With NUM_PORTS = 1, the grant equals eligibility and rr_ptr stays 0.

Decomposition:
- Package bank_sched_pkg:
  - PORT_ID_W = clog2(NUM_PORTS), minimum 1;
  - function in_range(addr, lo, hi);
  - resp pipe entry typedef {valid, port_id}.
- One sub-module, rr_arbiter (params N, RR_MODE; in: req[N]; out: gnt[N] one-hot, gnt_id). It owns rr_ptr, reset to 0 by rst_n.
- The top level does the range check, issue registers and response pipe.

Test Plan:
- Single read: port 2 reads addr 3, LOWER = 0, MEM_LATENCY = 1 -> ready[2] in cycle 0; mem_en = 1, mem_addr = 3 in cycle 1; rsp_valid = 4'b0100 with rsp_data = mem_rdata in cycle 2.
- Fixed priority: RR_MODE = 0, all 4 ports request in range and hold -> grants 0, 1, 2, 3 in successive cycles. In cycle 0, conflict = 4'b1110.
- Round robin: RR_MODE = 1, ports 0 and 3 request continuously -> grant sequence 0, 3, 0, 3. Neither port is starved.
- Range edges: LOWER = 8, UPPER = 12; ports request 7, 8, 12, 13 -> ports 0 and 3 never get ready or conflict. Port 1 issues mem_addr = 0; port 2 issues mem_addr = 4.
- Write then read: port 1 writes 0xDEADBEEF to addr 2, then port 0 reads addr 2 -> mem_we = 1, then 0 on consecutive cycles. Exactly one rsp_valid, for port 0 only.
- Mid-stream reset: two reads in flight with MEM_LATENCY = 3, rst_n pulsed low -> mem_en = 0 and rsp_valid = 0 immediately. No responses after release; first grant after release goes to port 0.

Source files
------------

// File: rtl/bank_sched_pkg.sv
// Shared types and helpers for the bank scheduler: port-id sizing,
// the address-window check and the read-response pipe entry.
package bank_sched_pkg;

  // Widest port id the response pipe can carry (up to 256 ports).
  localparam int PORT_ID_MAX_W = 8;

  // Port-id width for a given port count, never narrower than one bit.
  function automatic int portIdWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Inclusive window check; both bounds compared independently, unsigned.
  function automatic logic in_range(input logic [63:0] addr,
                                    input logic [63:0] lo,
                                    input logic [63:0] hi);
    logic geLo;
    logic leHi;
    geLo = (addr >= lo);
    leHi = (addr <= hi);
    return geLo && leHi;
  endfunction

  // One slot of the read-return pipe: valid only for reads.
  typedef struct packed {
    logic                     valid;
    logic [PORT_ID_MAX_W-1:0] portId;
  } rspEntry_t;

endpackage

// File: rtl/bank_scheduler_n_rr_arbiter.sv
// One-hot arbiter with either fixed priority (port 0 highest) or a
// round-robin pointer that moves past the last winner.
module rr_arbiter #(
  parameter int N       = 4,
  parameter int RR_MODE = 1,
  parameter int ID_W    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic [ID_W-1:0] rrPtr;

  // Pick the first requester, starting at rrPtr (round robin) or 0 (fixed).
  always_comb begin
    int  idx;
    logic found;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      if (RR_MODE != 0) idx = int'(rrPtr) + k;
      else              idx = k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found       = 1'b1;
        gnt[idx]    = 1'b1;
        gnt_id      = ID_W'(idx);
      end
    end
  end

  // Advance the pointer just past the winner; hold when nobody is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr <= '0;
    end else if (|req) begin
      rrPtr <= (gnt_id == ID_W'(N - 1)) ? '0 : gnt_id + ID_W'(1);
    end
  end

endmodule

// File: rtl/bank_scheduler_n.sv
// N-port scheduler in front of a single-port BRAM bank owning the global
// window [LOWER_ADDR, UPPER_ADDR]. One access issued per cycle through
// registered bank controls; read data routed back after MEM_LATENCY.
//
// Handshake: a transfer happens on any rising edge where req_valid[i] and
// req_ready[i] are both high. req_ready is combinational from the current
// request inputs; a requester keeps valid/we/addr/wdata stable until it sees
// ready. conflict[i] flags an in-window request that lost arbitration.
module bank_scheduler_n
  import bank_sched_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int ADDR_WIDTH  = 13,
  parameter int DATA_WIDTH  = 32,
  parameter int LOWER_ADDR  = 0,
  parameter int UPPER_ADDR  = 4,
  parameter int RR_MODE     = 1,
  parameter int MEM_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            req_valid,
  input  logic [NUM_PORTS-1:0]            req_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]            req_ready,
  output logic [NUM_PORTS-1:0]            conflict,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  output logic [NUM_PORTS-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_data
);

  localparam int ID_W = portIdWidth(NUM_PORTS);
  localparam logic [ADDR_WIDTH-1:0] LOWER_A = ADDR_WIDTH'(LOWER_ADDR);

  logic [NUM_PORTS-1:0]  eligible;
  logic [NUM_PORTS-1:0]  arbReq;
  logic [NUM_PORTS-1:0]  gnt;
  logic [ID_W-1:0]       gntId;
  logic                  selWe;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic [DATA_WIDTH-1:0] selWdata;
  logic [ID_W-1:0]       issueId;
  rspEntry_t             rspPipe [MEM_LATENCY];

  // A port competes only when valid and its address falls inside the window.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible[i] = req_valid[i] &
                    in_range(64'(req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
                             64'(LOWER_ADDR), 64'(UPPER_ADDR));
    end
  end

  // No grants while reset is asserted.
  assign arbReq = eligible & {NUM_PORTS{rst_n}};

  rr_arbiter #(
    .N       (NUM_PORTS),
    .RR_MODE (RR_MODE),
    .ID_W    (ID_W)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (arbReq),
    .gnt    (gnt),
    .gnt_id (gntId)
  );

  assign req_ready = gnt;
  assign conflict  = eligible & ~gnt;

  // One-hot mux of the winning port's request fields.
  always_comb begin
    selWe    = 1'b0;
    selAddr  = '0;
    selWdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt[i]) begin
        selWe    = req_we[i];
        selAddr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        selWdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Issue registers: translate to the bank-local address; hold addr/data when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      issueId   <= '0;
    end else if (|gnt) begin
      mem_en    <= 1'b1;
      mem_we    <= selWe;
      mem_addr  <= selAddr - LOWER_A;
      mem_wdata <= selWdata;
      issueId   <= gntId;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
    end
  end

  // Response pipe fed from the issued access, so its tail lines up with mem_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MEM_LATENCY; k++) rspPipe[k] <= '0;
    end else begin
      rspPipe[0] <= '{valid: mem_en & ~mem_we, portId: PORT_ID_MAX_W'(issueId)};
      for (int k = 1; k < MEM_LATENCY; k++) rspPipe[k] <= rspPipe[k-1];
    end
  end

  // Decode the pipe tail into the one-hot response strobe.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      rsp_valid[i] = rspPipe[MEM_LATENCY-1].valid &&
                     (rspPipe[MEM_LATENCY-1].portId == PORT_ID_MAX_W'(i));
    end
  end

  assign rsp_data = mem_rdata;

endmodule

// File: tb/tb_bank_scheduler_n.sv
// Bench for bank_scheduler_n: two instances (A: round robin, window [0,4],
// latency 1; B: fixed priority, window [8,12], latency 3) driven by directed
// steps then random traffic, checked against a transaction-level model.
module tb_bank_scheduler_n;

  localparam int N  = 4;
  localparam int AW = 13;
  localparam int DW = 32;

  // Clock / reset
  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    reqValid [2];
  logic [N-1:0]    reqWe    [2];
  logic [N*AW-1:0] reqAddr  [2];
  logic [N*DW-1:0] reqWdata [2];
  logic [DW-1:0]   memRdata [2];
  logic [N-1:0]    reqReady [2];
  logic [N-1:0]    conflict [2];
  logic            memEn    [2];
  logic            memWe    [2];
  logic [AW-1:0]   memAddr  [2];
  logic [DW-1:0]   memWdata [2];
  logic [N-1:0]    rspValid [2];
  logic [DW-1:0]   rspData  [2];

  bank_scheduler_n #(
    .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .LOWER_ADDR(0), .UPPER_ADDR(4), .RR_MODE(1), .MEM_LATENCY(1)
  ) dutA (
    .clk(clk), .rst_n(rstN),
    .req_valid(reqValid[0]), .req_we(reqWe[0]), .req_addr(reqAddr[0]),
    .req_wdata(reqWdata[0]), .req_ready(reqReady[0]), .conflict(conflict[0]),
    .mem_en(memEn[0]), .mem_we(memWe[0]), .mem_addr(memAddr[0]),
    .mem_wdata(memWdata[0]), .mem_rdata(memRdata[0]),
    .rsp_valid(rspValid[0]), .rsp_data(rspData[0])
  );

  bank_scheduler_n #(
    .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .LOWER_ADDR(8), .UPPER_ADDR(12), .RR_MODE(0), .MEM_LATENCY(3)
  ) dutB (
    .clk(clk), .rst_n(rstN),
    .req_valid(reqValid[1]), .req_we(reqWe[1]), .req_addr(reqAddr[1]),
    .req_wdata(reqWdata[1]), .req_ready(reqReady[1]), .conflict(conflict[1]),
    .mem_en(memEn[1]), .mem_we(memWe[1]), .mem_addr(memAddr[1]),
    .mem_wdata(memWdata[1]), .mem_rdata(memRdata[1]),
    .rsp_valid(rspValid[1]), .rsp_data(rspData[1])
  );

  // Reference model state, one set per instance
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lo  [2] = '{0, 8};
  int hi  [2] = '{4, 12};
  int rr  [2] = '{1, 0};
  int lat [2] = '{1, 3};
  int            rrPtr  [2];
  logic          mEn    [2];
  logic          mWe    [2];
  logic [AW-1:0] mAddr  [2];
  logic [DW-1:0] mWdata [2];
  int            expRsp [2][8];   // port expecting a response in cycle c%8, -1 = none
  int            gNow   [2];
  bit            autoStim = 1'b0;

  // Scoreboard compare
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic string nm(input int k);
    return (k == 0) ? "A" : "B";
  endfunction

  function automatic logic [N-1:0] eligibleOf(input int k);
    logic [N-1:0] el;
    int a;
    el = '0;
    for (int i = 0; i < N; i++) begin
      a = int'(reqAddr[k][i*AW +: AW]);
      el[i] = reqValid[k][i] && (a >= lo[k]) && (a <= hi[k]);
    end
    return el;
  endfunction

  // Winner per the arbitration rule, or -1.
  function automatic int modelGrant(input int k);
    logic [N-1:0] el;
    int p;
    el = eligibleOf(k);
    if (!rstN) return -1;
    for (int j = 0; j < N; j++) begin
      p = (rr[k] != 0) ? (rrPtr[k] + j) % N : j;
      if (el[p]) return p;
    end
    return -1;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      rrPtr[k] = 0; mEn[k] = 1'b0; mWe[k] = 1'b0; mAddr[k] = '0; mWdata[k] = '0;
      for (int j = 0; j < 8; j++) expRsp[k][j] = -1;
    end
  endtask

  // Driver: set one request port of instance k
  task automatic setPort(input int k, input int i, input bit v, input bit we,
                         input int addr, input logic [DW-1:0] d);
    reqValid[k][i] = v;
    reqWe[k][i] = we;
    reqAddr[k][i*AW +: AW] = AW'(addr);
    reqWdata[k][i*DW +: DW] = d;
  endtask

  // Compare all outputs mid-cycle
  task automatic checkCycle();
    logic [N-1:0] one;
    logic [N-1:0] el;
    logic [N-1:0] expReady;
    logic [N-1:0] expV;
    int g, e;
    one = 1;
    for (int k = 0; k < 2; k++) begin
      el = eligibleOf(k);
      g = modelGrant(k);
      gNow[k] = g;
      expReady = (g >= 0) ? (one << g) : '0;
      chk($sformatf("%s ready c%0d", nm(k), cyc), 64'(reqReady[k]), 64'(expReady));
      chk($sformatf("%s conflict c%0d", nm(k), cyc), 64'(conflict[k]), 64'(el & ~expReady));
      chk($sformatf("%s mem_en c%0d", nm(k), cyc), 64'(memEn[k]), 64'(mEn[k]));
      chk($sformatf("%s mem_we c%0d", nm(k), cyc), 64'(memWe[k]), 64'(mWe[k]));
      chk($sformatf("%s mem_addr c%0d", nm(k), cyc), 64'(memAddr[k]), 64'(mAddr[k]));
      chk($sformatf("%s mem_wdata c%0d", nm(k), cyc), 64'(memWdata[k]), 64'(mWdata[k]));
      e = expRsp[k][cyc % 8];
      expV = (e >= 0) ? (one << e) : '0;
      chk($sformatf("%s rsp_valid c%0d", nm(k), cyc), 64'(rspValid[k]), 64'(expV));
      if (e >= 0)
        chk($sformatf("%s rsp_data c%0d", nm(k), cyc), 64'(rspData[k]), 64'(memRdata[k]));
      expRsp[k][cyc % 8] = -1;
    end
  endtask

  // Clock edge: advance the model, then let requesters react
  task automatic stepEdge();
    int g;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      g = gNow[k];
      if (rstN && g >= 0) begin
        mEn[k]    = 1'b1;
        mWe[k]    = reqWe[k][g];
        mAddr[k]  = AW'(int'(reqAddr[k][g*AW +: AW]) - lo[k]);
        mWdata[k] = reqWdata[k][g*DW +: DW];
        rrPtr[k]  = (g + 1) % N;
        if (!reqWe[k][g]) expRsp[k][(cyc + 1 + lat[k]) % 8] = g;
      end else begin
        mEn[k] = 1'b0;
        mWe[k] = 1'b0;
      end
    end
    cyc++;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (gNow[k] >= 0) reqValid[k][gNow[k]] = 1'b0;
      memRdata[k] = $urandom;
      if (autoStim)
        for (int i = 0; i < N; i++)
          if (!reqValid[k][i])
            setPort(k, i, ($urandom_range(0, 99) < 50), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 15)), $urandom);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    checkCycle();
    stepEdge();
  endtask

  // Async reset pulse in the middle of a cycle, held for two edges
  task automatic pulseReset();
    #2 rstN = 1'b0;
    #1;
    modelReset();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s mem_en at reset", nm(k)), 64'(memEn[k]), 64'(0));
      chk($sformatf("%s rsp_valid at reset", nm(k)), 64'(rspValid[k]), 64'(0));
    end
    cycle();
    cycle();
    rstN = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      reqValid[k] = '0; reqWe[k] = '0; reqAddr[k] = '0; reqWdata[k] = '0;
      memRdata[k] = '0; gNow[k] = -1;
    end
    modelReset();

    // Reset state
    cycle();
    cycle();
    rstN = 1'b1;

    // Single read: A port 2 reads address 3
    setPort(0, 2, 1, 0, 3, '0);
    repeat (4) cycle();

    // Fixed priority on B (all ports hold); round robin on A with ports 0 and 3
    for (int i = 0; i < N; i++) setPort(1, i, 1, 0, 8 + i, $urandom);
    for (int j = 0; j < 6; j++) begin
      if (!reqValid[0][0]) setPort(0, 0, 1, 0, 1, '0);
      if (!reqValid[0][3]) setPort(0, 3, 1, 0, 4, '0);
      cycle();
    end
    reqValid[0] = '0;
    repeat (4) cycle();

    // Window edges on B: 7 and 13 out, 8 and 12 in; A: 4 in, 5 out
    setPort(1, 0, 1, 0, 7, '0);
    setPort(1, 1, 1, 0, 8, '0);
    setPort(1, 2, 1, 0, 12, '0);
    setPort(1, 3, 1, 0, 13, '0);
    setPort(0, 1, 1, 0, 4, '0);
    setPort(0, 2, 1, 0, 5, '0);
    repeat (5) cycle();
    reqValid[0] = '0;
    reqValid[1] = '0;

    // Write then read on A
    setPort(0, 1, 1, 1, 2, 32'hDEADBEEF);
    cycle();
    setPort(0, 0, 1, 0, 2, '0);
    repeat (4) cycle();

    // Mid-stream reset with reads in flight on both instances
    setPort(1, 1, 1, 0, 9, '0);
    setPort(1, 2, 1, 0, 10, '0);
    setPort(0, 1, 1, 0, 1, '0);
    setPort(0, 2, 1, 0, 2, '0);
    cycle();
    cycle();
    pulseReset();
    for (int i = 0; i < N; i++) begin
      setPort(0, i, 1, 0, i, '0);
      setPort(1, i, 1, 0, 8 + i, '0);
    end
    repeat (6) cycle();

    // Random traffic with one reset in the middle
    autoStim = 1'b1;
    repeat (200) cycle();
    pulseReset();
    repeat (200) cycle();

    // Drain
    autoStim = 1'b0;
    reqValid[0] = '0;
    reqValid[1] = '0;
    repeat (6) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
